// File: rtl/vmicro16_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vmicro16_boot_ctrl
// Brief    : Boot controller for vmicro16_soc. Holds the cores in reset,
//            loads a checksummed image from a UART byte stream into the
//            instruction memory, then releases the cores after a hold time.
// Revision : 1.0 - initial release
// ============================================================================
module vmicro16_boot_ctrl #(
  parameter int              ADDR_WIDTH = 8,
  parameter int              MEM_DEPTH  = 256,
  parameter logic [7:0]      MAGIC      = 8'hA5,
  parameter int              RESET_HOLD = 4,
  parameter logic [15:0]     TIMEOUT    = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boot_skip,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  boot_done,
  output logic                  boot_err
);

  // Length bound widened by one bit so a 16-bit length compares cleanly.
  localparam logic [16:0] c_mem_depth = 17'(MEM_DEPTH);
  // Hold counter terminal value: the RUN transition happens on the
  // RESET_HOLD-th edge after HOLD entry.
  localparam logic [15:0] c_hold_last = 16'(RESET_HOLD - 1);
  // Idle counter value at which the next idle edge makes it reach TIMEOUT.
  localparam logic [15:0] c_idle_last = TIMEOUT - 16'd1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_CSUM    = 4'd5,
    S_HOLD    = 4'd6,
    S_RUN     = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [7:0]            r_data_hi;
  logic [7:0]            r_csum;
  logic [15:0]           r_idle_cnt;
  logic [15:0]           r_hold_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_wdata;
  logic                  r_core_reset;
  logic                  r_boot_done;
  logic                  r_boot_err;

  logic                  w_accept;
  logic                  w_loading;
  logic [15:0]           w_len;
  logic [15:0]           w_next_idx;

  // Only HOLD and RUN refuse bytes; everywhere else the stream is consumed.
  assign rx_ready   = (r_state != S_HOLD) && (r_state != S_RUN);
  assign w_accept   = rx_valid && rx_ready;
  // States in which a stalled sender is timed out.
  assign w_loading  = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                      (r_state == S_CSUM);
  assign w_len      = {r_len_hi, rx_data};
  assign w_next_idx = 16'(r_idx) + 16'd1;

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_reset = r_core_reset;
  assign boot_done  = r_boot_done;
  assign boot_err   = r_boot_err;

  // Load FSM with registered outputs; the write strobe is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len_hi     <= 8'd0;
      r_len        <= 16'd0;
      r_idx        <= '0;
      r_data_hi    <= 8'd0;
      r_csum       <= 8'd0;
      r_idle_cnt   <= 16'd0;
      r_hold_cnt   <= 16'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 16'd0;
      r_core_reset <= 1'b1;
      r_boot_done  <= 1'b0;
      r_boot_err   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // boot_skip wins over a byte arriving in the same cycle.
          if (boot_skip) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= 16'd0;
          end else if (w_accept && (rx_data == MAGIC)) begin
            r_state <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= rx_data;
            r_state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (w_accept) begin
            r_len  <= w_len;
            r_idx  <= '0;
            r_csum <= 8'd0;
            if ({1'b0, w_len} > c_mem_depth) begin
              r_state    <= S_ERR;
              r_boot_err <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end

        S_DATA_HI: begin
          if (w_accept) begin
            r_data_hi <= rx_data;
            r_csum    <= r_csum ^ rx_data;
            r_state   <= S_DATA_LO;
          end
        end

        S_DATA_LO: begin
          if (w_accept) begin
            r_csum      <= r_csum ^ rx_data;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_idx;
            r_mem_wdata <= {r_data_hi, rx_data};
            r_idx       <= r_idx + ADDR_WIDTH'(1);
            if (w_next_idx == r_len) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end

        S_CSUM: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= 16'd0;
            end else begin
              r_state    <= S_ERR;
              r_boot_err <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (r_hold_cnt == c_hold_last) begin
            r_state      <= S_RUN;
            r_core_reset <= 1'b0;
            r_boot_done  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end

        S_RUN: begin
          // Terminal: only reset leaves RUN.
        end

        S_ERR: begin
          // A new MAGIC restarts the load; partial memory contents are kept.
          if (w_accept && (rx_data == MAGIC)) begin
            r_boot_err <= 1'b0;
            r_state    <= S_LEN_HI;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Idle watchdog: every accept restarts it; a long stall mid-image
      // abandons the load.
      if (w_accept) begin
        r_idle_cnt <= 16'd0;
      end else if (w_loading) begin
        if (r_idle_cnt == c_idle_last) begin
          r_state    <= S_ERR;
          r_boot_err <= 1'b1;
          r_idle_cnt <= 16'd0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
